// File: rtl/fifo_rd_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO read port among NUM_REQ requesters.
// Define FIFO_RD_ARB_STATS_EN to count delivered words in status[31:16].
module fifo_rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int USEDW_W   = 8,
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic [2:0]         rd_id,
    output logic               fifo_rdreq,
    input  logic [DATA_W-1:0]  fifo_q,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic [31:0]        status
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [2:0]         owner_reg, owner_next;
    logic [2:0]         rr_ptr_reg, rr_ptr_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [31:0]        status_reg;
    logic [15:0]        stats_word;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [2:0]           pick_off;
    logic [3:0]           pick_sum;
    logic [2:0]           pick_id;
    logic                 pick_found;
    logic                 owner_req;
    logic                 last_issue;

    logic       pipe_valid_reg [RD_LAT];
    logic [2:0] pipe_id_reg    [RD_LAT];

    // Rotate requests so bit 0 is the round-robin pointer position.
    assign req_dbl    = {req, req} >> rr_ptr_reg;
    assign req_rot    = req_dbl[NUM_REQ-1:0];
    assign pick_found = |req_rot;

    always_comb begin
        pick_off = 3'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) pick_off = 3'(k);
        end
        pick_sum = {1'b0, rr_ptr_reg} + {1'b0, pick_off};
        if (pick_sum >= 4'(NUM_REQ)) pick_id = 3'(pick_sum - 4'(NUM_REQ));
        else                         pick_id = pick_sum[2:0];
    end

    assign owner_req  = |(grant_reg & req);
    assign fifo_rdreq = (state_reg == BURST) && owner_req && !fifo_empty;
    assign last_issue = fifo_rdreq && (cnt_reg == 4'(MAX_BURST - 1));

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found && !fifo_empty) begin
                    state_next = BURST;
                    grant_next = NUM_REQ'(1) << pick_id;
                    owner_next = pick_id;
                    cnt_next   = 4'd0;
                end
            end
            BURST: begin
                if (fifo_rdreq) cnt_next = cnt_reg + 4'd1;
                if (!owner_req || fifo_empty || last_issue) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    rr_ptr_next = (owner_reg == 3'(NUM_REQ - 1)) ? 3'd0 : owner_reg + 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            owner_reg  <= 3'd0;
            rr_ptr_reg <= 3'd0;
            cnt_reg    <= 4'd0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Return pipe tracks which requester each issued read belongs to.
    genvar gi;
    for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
        logic       valid_in;
        logic [2:0] id_in;
        if (gi == 0) begin : g_head
            assign valid_in = fifo_rdreq;
            assign id_in    = owner_reg;
        end else begin : g_tail
            assign valid_in = pipe_valid_reg[gi-1];
            assign id_in    = pipe_id_reg[gi-1];
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_valid_reg[gi] <= 1'b0;
                pipe_id_reg[gi]    <= 3'd0;
            end else begin
                pipe_valid_reg[gi] <= valid_in;
                pipe_id_reg[gi]    <= id_in;
            end
        end
    end

    assign rd_valid = pipe_valid_reg[RD_LAT-1];
    assign rd_id    = pipe_id_reg[RD_LAT-1];
    assign rd_data  = rd_valid ? fifo_q : '0;
    assign grant    = grant_reg;

`ifdef FIFO_RD_ARB_STATS_EN
    logic [15:0] stats_cnt_reg;
    always_ff @(posedge clk) begin
        if (rst)                                    stats_cnt_reg <= 16'd0;
        else if (rd_valid && stats_cnt_reg != 16'hFFFF) stats_cnt_reg <= stats_cnt_reg + 16'd1;
    end
    assign stats_word = stats_cnt_reg;
`else
    assign stats_word = 16'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) status_reg <= 32'd0;
        else     status_reg <= {stats_word, 2'b00, owner_reg, (state_reg == BURST),
                                fifo_empty, fifo_full, 8'(fifo_usedw)};
    end

    assign status = status_reg;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Randomized bench for fifo_rd_arbiter against a transaction-level arbitration model.
// Honours FIFO_RD_ARB_STATS_EN for the expected status[31:16].
module tb_fifo_rd_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int RD_LAT    = 1;

    logic               clk;
    logic               rst;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               rd_valid;
    logic [DATA_W-1:0]  rd_data;
    logic [2:0]         rd_id;
    logic               fifo_rdreq;
    logic [DATA_W-1:0]  fifo_q;
    logic               fifo_empty;
    logic               fifo_full;
    logic [7:0]         fifo_usedw;
    logic [31:0]        status;

    fifo_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .USEDW_W(8),
        .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id),
        .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_usedw(fifo_usedw), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } pend_t;

    int n_cmp = 0;
    int n_err = 0;

    // Environment FIFO
    int          level = 0;
    int          pops  = 0;
    int          add_n = 0;
    logic [31:0] q_pipe [RD_LAT];

    // Reference model
    bit          m_busy  = 0;
    int          m_owner = 0;
    int          m_ptr   = 0;
    int          m_cnt   = 0;
    int          m_stats = 0;
    int          cyc     = 0;
    logic [31:0] status_exp = 32'd0;
    pend_t       dq[$];

    logic [NUM_REQ-1:0] exp_grant;
    bit                 exp_rdreq;
    bit                 exp_valid;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic run_cycle();
        fifo_empty = (level == 0);
        fifo_full  = (level == 255);
        fifo_usedw = 8'(level);
        fifo_q     = q_pipe[RD_LAT-1];

        exp_grant = m_busy ? (NUM_REQ'(1) << m_owner) : '0;
        exp_rdreq = m_busy && req[m_owner] && (level != 0);
        exp_valid = (dq.size() > 0) && (dq[0].due == cyc);

        @(negedge clk);
        check_eq("grant", 32'(grant), 32'(exp_grant));
        check_eq("fifo_rdreq", 32'(fifo_rdreq), 32'(exp_rdreq));
        check_eq("rd_valid", 32'(rd_valid), 32'(exp_valid));
        check_eq("status", status, status_exp);
        if (exp_valid) begin
            check_eq("rd_id", 32'(rd_id), 32'(dq[0].id));
            check_eq("rd_data", rd_data, dq[0].data);
            $display("cycle %0d: word id=%0d data=%h", cyc, rd_id, rd_data);
        end else begin
            check_eq("rd_data_idle", rd_data, 32'd0);
        end

        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_stats = 0;
            status_exp = 32'd0;
            dq.delete();
        end else begin
`ifdef FIFO_RD_ARB_STATS_EN
            status_exp = {16'(m_stats), 2'b00, 3'(m_owner), m_busy, (level == 0), (level == 255), 8'(level)};
`else
            status_exp = {16'd0, 2'b00, 3'(m_owner), m_busy, (level == 0), (level == 255), 8'(level)};
`endif
            if (exp_valid) begin
                void'(dq.pop_front());
                if (m_stats < 65535) m_stats++;
            end
            if (!m_busy) begin
                if (level > 0 && req != 0) begin
                    for (int off = NUM_REQ - 1; off >= 0; off--) begin
                        if (req[(m_ptr + off) % NUM_REQ]) m_owner = (m_ptr + off) % NUM_REQ;
                    end
                    m_busy = 1;
                    m_cnt  = 0;
                end
            end else begin
                if (exp_rdreq) begin
                    m_cnt++;
                    dq.push_back('{id: m_owner, data: 32'hC0DE0000 + 32'(pops), due: cyc + RD_LAT});
                end
                if (!req[m_owner] || level == 0 || m_cnt == MAX_BURST) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % NUM_REQ;
                end
            end
        end

        for (int i = RD_LAT - 1; i > 0; i--) q_pipe[i] = q_pipe[i-1];
        if (exp_rdreq) begin
            q_pipe[0] = 32'hC0DE0000 + 32'(pops);
            pops++;
            level--;
        end else begin
            q_pipe[0] = 32'hBAD00000 + 32'(cyc);
        end
        level = (level + add_n > 255) ? 255 : level + add_n;
        cyc++;
        #1;
    endtask

    task automatic run_n(input int n, input logic [NUM_REQ-1:0] r);
        req   = r;
        add_n = 0;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        fifo_empty = 1'b1; fifo_full = 1'b0; fifo_usedw = 8'd0;
        for (int i = 0; i < RD_LAT; i++) q_pipe[i] = 32'd0;
        fifo_q = 32'd0;
        @(posedge clk);
        #1;

        // Reset held, then requests against an empty FIFO
        run_n(3, 4'b0000);
        rst = 1'b0;
        run_n(5, 4'b1111);

        // Single requester, bounded bursts with idle gap
        level = 10;
        run_n(14, 4'b0100);
        run_n(3, 4'b0000);

        // All requesting: strict rotation
        level = 200;
        run_n(40, 4'b1111);
        run_n(3, 4'b0000);

        // Short FIFO: empty ends the burst
        level = 2;
        run_n(10, 4'b0010);

        // Full FIFO status
        level = 255;
        run_n(3, 4'b0000);

        // Reset mid-burst with a word in the pipe
        level = 50;
        run_n(3, 4'b0001);
        rst = 1'b1;
        run_n(1, 4'b0001);
        rst = 1'b0;
        run_n(3, 4'b0001);

        // Randomized traffic with occasional resets and refills
        req = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            add_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
            rst   = ($urandom_range(0, 149) == 0);
            run_cycle();
        end
        rst = 1'b0;
        run_n(5, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
